// File: rtl/lm32_dtlb_walker_pkg.sv
// Shared definitions for the DTLB page-table walker.
// Provides the walker state encoding, fault cause codes, PTE and VA field
// ranges, and a helper that forms a word-aligned PTE address.
package lm32_dtlb_walker_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PN_W   = 20;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned TMO_W  = 8;

  // PTE fields
  localparam int unsigned PTE_VALID  = 0;
  localparam int unsigned PTE_PFN_HI = 31;
  localparam int unsigned PTE_PFN_LO = 12;

  // Virtual address fields
  localparam int unsigned VA_L1_HI  = 31;
  localparam int unsigned VA_L1_LO  = 22;
  localparam int unsigned VA_L2_HI  = 21;
  localparam int unsigned VA_L2_LO  = 12;
  localparam int unsigned VA_OFF_HI = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_L1    = 3'd1,
    ST_L2    = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } walk_state_e;

  typedef enum logic [1:0] {
    CAUSE_L1_INV  = 2'd0,
    CAUSE_L2_INV  = 2'd1,
    CAUSE_BUS_ERR = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } fault_cause_e;

  // Word address of entry idx in the table whose base page number is base.
  function automatic logic [ADDR_W-1:0] pte_addr(input logic [PN_W-1:0] base,
                                                 input logic [IDX_W-1:0] idx);
    return {base, idx, 2'b00};
  endfunction

endpackage

// File: rtl/lm32_wb_read_port.sv
// Single-beat Wishbone-classic read master with a wait-state timeout.
// Ports: clk_i/rst_i; start/start_addr launch a read (only while idle);
// wb_* is the master bus; done_c/bus_err_c/timeout_c are one-cycle
// combinational completion flags, rdata_c carries wb_dat_i on done_c.
module lm32_wb_read_port
  import lm32_dtlb_walker_pkg::*;
#(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  input  logic [ADDR_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              done_c,
  output logic              bus_err_c,
  output logic              timeout_c,
  output logic [ADDR_W-1:0] rdata_c
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

  logic              cyc_q;
  logic [ADDR_W-1:0] adr_q;
  logic [TMO_W-1:0]  cnt_q;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_adr_o = adr_q;

  // Error takes priority over a simultaneous ack.
  assign bus_err_c = cyc_q & wb_err_i;
  assign done_c    = cyc_q & wb_ack_i & ~wb_err_i;
  assign timeout_c = cyc_q & ~wb_ack_i & ~wb_err_i & (cnt_q == TMO_LAST);
  assign rdata_c   = wb_dat_i;

  // Bus cycle and wait-state counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      adr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      cyc_q <= 1'b1;
      adr_q <= start_addr;
      cnt_q <= '0;
    end else if (cyc_q) begin
      if (wb_ack_i || wb_err_i || (cnt_q == TMO_LAST)) begin
        cyc_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + TMO_W'(1);
      end
    end
  end

endmodule

// File: rtl/lm32_dtlb_walker.sv
// Two-level hardware page-table walker refilling the DTLB on a miss.
// Ports: clk_i/rst_i; miss_i/miss_addr_i from the DTLB; flush_i discards the
// in-flight result; ptbr_we_i/ptbr_wdata_i write the table base (ptbr_o);
// wb_* Wishbone-classic read master; update_* one-cycle refill;
// fault_* one-cycle page fault with held cause/address; busy_o walk active.
module lm32_dtlb_walker
  import lm32_dtlb_walker_pkg::*;
#(
  parameter logic [31:0] ptbr_reset     = 32'h0000_0000,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_i,
  input  logic [31:0] miss_addr_i,
  input  logic        flush_i,
  input  logic        ptbr_we_i,
  input  logic [31:0] ptbr_wdata_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        update_o,
  output logic [31:0] update_vaddr_o,
  output logic [31:0] update_paddr_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fault_addr_o,
  output logic        busy_o,
  output logic [31:0] ptbr_o
);

  walk_state_e       state_q, state_d;
  logic [ADDR_W-1:0] va_q, va_d;
  logic [ADDR_W-1:0] l2_adr_q, l2_adr_d;
  logic              l2_pend_q, l2_pend_d;
  logic [PN_W-1:0]   pfn_q, pfn_d;
  fault_cause_e      cause_q, cause_d;
  logic              stale_q, stale_d;
  logic [PN_W-1:0]   ptbr_q, ptbr_d;
  logic              update_q, update_d;
  logic [31:0]       upd_vaddr_q, upd_vaddr_d;
  logic [31:0]       upd_paddr_q, upd_paddr_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_cause_q, fault_cause_d;
  logic [31:0]       fault_addr_q, fault_addr_d;
  logic              busy_q, busy_d;

  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done, rd_err, rd_tmo;
  logic [ADDR_W-1:0] rd_data;

  // Reserved PTE bits and the low base bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{rd_data[PTE_PFN_LO-1:1], ptbr_wdata_i[VA_OFF_HI:0]};

  lm32_wb_read_port #(
    .timeout_cycles(timeout_cycles)
  ) u_rd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (rd_start),
    .start_addr(rd_addr),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .done_c    (rd_done),
    .bus_err_c (rd_err),
    .timeout_c (rd_tmo),
    .rdata_c   (rd_data)
  );

  assign update_o       = update_q;
  assign update_vaddr_o = upd_vaddr_q;
  assign update_paddr_o = upd_paddr_q;
  assign fault_o        = fault_q;
  assign fault_cause_o  = fault_cause_q;
  assign fault_addr_o   = fault_addr_q;
  assign busy_o         = busy_q;
  assign ptbr_o         = {ptbr_q, 12'h000};

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      va_q          <= '0;
      l2_adr_q      <= '0;
      l2_pend_q     <= 1'b0;
      pfn_q         <= '0;
      cause_q       <= CAUSE_L1_INV;
      stale_q       <= 1'b0;
      ptbr_q        <= ptbr_reset[PTE_PFN_HI:PTE_PFN_LO];
      update_q      <= 1'b0;
      upd_vaddr_q   <= '0;
      upd_paddr_q   <= '0;
      fault_q       <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      va_q          <= va_d;
      l2_adr_q      <= l2_adr_d;
      l2_pend_q     <= l2_pend_d;
      pfn_q         <= pfn_d;
      cause_q       <= cause_d;
      stale_q       <= stale_d;
      ptbr_q        <= ptbr_d;
      update_q      <= update_d;
      upd_vaddr_q   <= upd_vaddr_d;
      upd_paddr_q   <= upd_paddr_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
      busy_q        <= busy_d;
    end
  end

  // Walk sequencing and next-state values
  always_comb begin
    state_d       = state_q;
    va_d          = va_q;
    l2_adr_d      = l2_adr_q;
    l2_pend_d     = l2_pend_q;
    pfn_d         = pfn_q;
    cause_d       = cause_q;
    stale_d       = stale_q;
    ptbr_d        = ptbr_we_i ? ptbr_wdata_i[PTE_PFN_HI:PTE_PFN_LO] : ptbr_q;
    update_d      = 1'b0;
    upd_vaddr_d   = upd_vaddr_q;
    upd_paddr_d   = upd_paddr_q;
    fault_d       = 1'b0;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    rd_start      = 1'b0;
    rd_addr       = '0;

    if ((state_q != ST_IDLE) && flush_i) stale_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (miss_i) begin
          va_d     = miss_addr_i;
          stale_d  = 1'b0;
          rd_start = 1'b1;
          rd_addr  = pte_addr(ptbr_q, miss_addr_i[VA_L1_HI:VA_L1_LO]);
          state_d  = ST_L1;
        end
      end
      ST_L1: begin
        if (rd_err) begin
          cause_d = CAUSE_BUS_ERR;
          state_d = ST_FAULT;
        end else if (rd_tmo) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_FAULT;
        end else if (rd_done) begin
          if (rd_data[PTE_VALID]) begin
            // L2 read launches one cycle later, leaving a bus-idle gap.
            l2_adr_d  = pte_addr(rd_data[PTE_PFN_HI:PTE_PFN_LO], va_q[VA_L2_HI:VA_L2_LO]);
            l2_pend_d = 1'b1;
            state_d   = ST_L2;
          end else begin
            cause_d = CAUSE_L1_INV;
            state_d = ST_FAULT;
          end
        end
      end
      ST_L2: begin
        if (l2_pend_q) begin
          rd_start  = 1'b1;
          rd_addr   = l2_adr_q;
          l2_pend_d = 1'b0;
        end else if (rd_err) begin
          cause_d = CAUSE_BUS_ERR;
          state_d = ST_FAULT;
        end else if (rd_tmo) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_FAULT;
        end else if (rd_done) begin
          if (rd_data[PTE_VALID]) begin
            pfn_d   = rd_data[PTE_PFN_HI:PTE_PFN_LO];
            state_d = ST_DONE;
          end else begin
            cause_d = CAUSE_L2_INV;
            state_d = ST_FAULT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!(stale_q || flush_i)) begin
          update_d    = 1'b1;
          upd_vaddr_d = {va_q[VA_L1_HI:VA_L2_LO], 12'h000};
          upd_paddr_d = {pfn_q, 12'h000};
        end
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
        if (!(stale_q || flush_i)) begin
          fault_d       = 1'b1;
          fault_cause_d = cause_q;
          fault_addr_d  = va_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Self-checking bench for lm32_dtlb_walker: directed vector table, randomized
// walks against a page-table reference model, and multi-cycle corner cases.
module tb_lm32_dtlb_walker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        miss_i = 1'b0;
  logic [31:0] miss_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        ptbr_we_i = 1'b0;
  logic [31:0] ptbr_wdata_i = '0;
  logic        wb_cyc_o, wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        update_o, fault_o, busy_o;
  logic [31:0] update_vaddr_o, update_paddr_o, fault_addr_o, ptbr_o;
  logic [1:0]  fault_cause_o;

  always #5 clk_i = ~clk_i;

  lm32_dtlb_walker #(
    .ptbr_reset    (32'h0000_0000),
    .timeout_cycles(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .miss_i        (miss_i),
    .miss_addr_i   (miss_addr_i),
    .flush_i       (flush_i),
    .ptbr_we_i     (ptbr_we_i),
    .ptbr_wdata_i  (ptbr_wdata_i),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .update_o      (update_o),
    .update_vaddr_o(update_vaddr_o),
    .update_paddr_o(update_paddr_o),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .fault_addr_o  (fault_addr_o),
    .busy_o        (busy_o),
    .ptbr_o        (ptbr_o)
  );

  // Memory-backed slave: zero-wait ack unless hung, optional error at one address.
  logic [31:0] mem [logic [31:0]];
  logic        hang = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = '0;
  logic        prev_cyc = 1'b0;
  logic [31:0] rd_q [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk_i) begin
    wb_ack_i <= wb_cyc_o & wb_stb_o & ~hang;
    wb_err_i <= wb_cyc_o & wb_stb_o & err_en & (wb_adr_o == err_adr);
    wb_dat_i <= mem_rd(wb_adr_o);
    prev_cyc <= wb_cyc_o;
    if (wb_cyc_o && !prev_cyc) rd_q.push_back(wb_adr_o);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Results of the last walk
  int          n_upd, n_flt, lat, lat2;
  logic [31:0] vaddr, paddr, faddr, cyc_hist, busy_hist;
  logic [1:0]  cause;

  // Issue one miss and observe 30 cycles; optional one-cycle action at cycle act_cyc
  // (1 = flush, 2 = ptbr write of act_data).
  task automatic run_walk(input logic [31:0] va, input int act_cyc, input int act_kind,
                          input logic [31:0] act_data);
    n_upd = 0; n_flt = 0; lat = -1;
    vaddr = '0; paddr = '0; faddr = '0; cause = '0; cyc_hist = '0; busy_hist = '0;
    rd_q.delete();
    miss_i = 1'b1;
    miss_addr_i = va;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_i);
      miss_i = 1'b0; flush_i = 1'b0; ptbr_we_i = 1'b0;
      if (i == act_cyc && act_kind == 1) flush_i = 1'b1;
      if (i == act_cyc && act_kind == 2) begin
        ptbr_we_i = 1'b1;
        ptbr_wdata_i = act_data;
      end
      cyc_hist[i] = wb_cyc_o;
      busy_hist[i] = busy_o;
      if (update_o) begin
        n_upd++;
        if (lat < 0) lat = i;
        vaddr = update_vaddr_o;
        paddr = update_paddr_o;
      end
      if (fault_o) begin
        n_flt++;
        if (lat < 0) lat = i;
        cause = fault_cause_o;
        faddr = fault_addr_o;
      end
    end
  endtask

  task automatic set_ptbr(input logic [31:0] v);
    ptbr_we_i = 1'b1;
    ptbr_wdata_i = v;
    @(negedge clk_i);
    ptbr_we_i = 1'b0;
    chk("ptbr_o", ptbr_o, v & 32'hFFFF_F000);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
    chk({tag, "_adr"}, wb_adr_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_upd"}, 32'(update_o), 32'd0);
    chk({tag, "_flt"}, 32'(fault_o), 32'd0);
    chk({tag, "_cause"}, 32'(fault_cause_o), 32'd0);
    chk({tag, "_faddr"}, fault_addr_o, 32'd0);
    chk({tag, "_vaddr"}, update_vaddr_o, 32'd0);
    chk({tag, "_paddr"}, update_paddr_o, 32'd0);
    chk({tag, "_ptbr"}, ptbr_o, 32'd0);
  endtask

  // Reference model: walk the table held in mem with plain address arithmetic.
  int          m_kind, m_nreads;
  logic [31:0] m_a1, m_a2, m_vaddr, m_paddr;
  logic [1:0]  m_cause;

  task automatic model(input logic [31:0] pb, input logic [31:0] va);
    logic [31:0] p1, p2;
    m_a1 = (pb & 32'hFFFF_F000) + ((va >> 22) * 32'd4);
    m_a2 = '0;
    p1 = mem_rd(m_a1);
    m_nreads = 1; m_kind = 2; m_cause = 2'd0; m_paddr = '0;
    m_vaddr = va & 32'hFFFF_F000;
    if (p1[0]) begin
      m_a2 = (p1 & 32'hFFFF_F000) + (((va >> 12) & 32'h3FF) * 32'd4);
      p2 = mem_rd(m_a2);
      m_nreads = 2;
      if (p2[0]) begin
        m_kind = 1;
        m_paddr = p2 & 32'hFFFF_F000;
      end else begin
        m_cause = 2'd1;
      end
    end
  endtask

  typedef struct {
    logic [31:0] ptbr, va, l1a, pte1, l2a, pte2;
    logic        err_l2;
    int          upd, flt, lat, nreads;
    logic [31:0] vaddr, paddr;
    logic [1:0]  cause;
    logic [31:0] cyc;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] r_pb, r_va, r_b2, r_p1, r_p2, r_a1, r_a2, r_lo;
  logic        r_v1, r_v2;

  initial begin
    //            ptbr          va            l1a           pte1          l2a           pte2          err upd flt lat nrd vaddr         paddr         cause cyc
    vecs[0] = '{32'h0010_0000, 32'h0040_2123, 32'h0010_0004, 32'h0020_0001, 32'h0020_0008, 32'hABCD_E001, 1'b0, 1, 0, 5, 2, 32'h0040_2000, 32'hABCD_E000, 2'd0, 32'hA};
    vecs[1] = '{32'h0010_0000, 32'h0040_2123, 32'h0010_0004, 32'h0020_0000, 32'h0020_0008, 32'hABCD_E001, 1'b0, 0, 1, 3, 1, 32'h0, 32'h0, 2'd0, 32'h2};
    vecs[2] = '{32'h0010_0000, 32'h0040_2123, 32'h0010_0004, 32'h0020_0001, 32'h0020_0008, 32'hABCD_E000, 1'b0, 0, 1, 5, 2, 32'h0, 32'h0, 2'd1, 32'hA};
    vecs[3] = '{32'h0010_0000, 32'h0040_2123, 32'h0010_0004, 32'h0020_0001, 32'h0020_0008, 32'hABCD_E001, 1'b1, 0, 1, 5, 2, 32'h0, 32'h0, 2'd2, 32'hA};
    vecs[4] = '{32'h0010_0000, 32'hFFC0_0FFF, 32'h0010_0FFC, 32'h1234_5FFF, 32'h1234_5000, 32'h0000_1003, 1'b0, 1, 0, 5, 2, 32'hFFC0_0000, 32'h0000_1000, 2'd0, 32'hA};

    repeat (3) @(negedge clk_i);
    check_reset_vals("por");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed vectors
    for (int k = 0; k < 5; k++) begin
      set_ptbr(vecs[k].ptbr);
      mem.delete();
      mem[vecs[k].l1a] = vecs[k].pte1;
      mem[vecs[k].l2a] = vecs[k].pte2;
      err_en = vecs[k].err_l2;
      err_adr = vecs[k].l2a;
      run_walk(vecs[k].va, 0, 0, 32'h0);
      err_en = 1'b0;
      chk($sformatf("v%0d_nupd", k), n_upd, vecs[k].upd);
      chk($sformatf("v%0d_nflt", k), n_flt, vecs[k].flt);
      chk($sformatf("v%0d_lat", k), lat, vecs[k].lat);
      chk($sformatf("v%0d_nreads", k), rd_q.size(), vecs[k].nreads);
      chk($sformatf("v%0d_rd0", k), (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_DEAD, vecs[k].l1a);
      if (vecs[k].nreads == 2)
        chk($sformatf("v%0d_rd1", k), (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_DEAD, vecs[k].l2a);
      if (vecs[k].upd == 1) begin
        chk($sformatf("v%0d_vaddr", k), vaddr, vecs[k].vaddr);
        chk($sformatf("v%0d_paddr", k), paddr, vecs[k].paddr);
      end else begin
        chk($sformatf("v%0d_cause", k), 32'(cause), 32'(vecs[k].cause));
        chk($sformatf("v%0d_faddr", k), faddr, vecs[k].va);
      end
      chk($sformatf("v%0d_cyc", k), cyc_hist & 32'h3F, vecs[k].cyc);
      chk($sformatf("v%0d_busy", k), 32'(busy_o), 32'd0);
    end

    // Randomized walks against the reference model
    for (int r = 0; r < 24; r++) begin
      r_pb = $urandom();
      r_va = $urandom();
      r_b2 = $urandom();
      r_p2 = $urandom();
      r_lo = $urandom();
      r_v1 = ($urandom_range(0, 3) != 0);
      r_v2 = ($urandom_range(0, 3) != 0);
      r_p1 = (r_b2 & 32'hFFFF_F000) | (r_lo & 32'h0000_0FFE) | {31'd0, r_v1};
      r_p2 = (r_p2 & 32'hFFFF_FFFE) | {31'd0, r_v2};
      set_ptbr(r_pb);
      mem.delete();
      r_a1 = (r_pb & 32'hFFFF_F000) + ((r_va >> 22) * 32'd4);
      mem[r_a1] = r_p1;
      r_a2 = (r_p1 & 32'hFFFF_F000) + (((r_va >> 12) & 32'h3FF) * 32'd4);
      mem[r_a2] = r_p2;
      model(r_pb, r_va);
      run_walk(r_va, 0, 0, 32'h0);
      chk($sformatf("r%0d_nupd", r), n_upd, (m_kind == 1) ? 1 : 0);
      chk($sformatf("r%0d_nflt", r), n_flt, (m_kind == 2) ? 1 : 0);
      chk($sformatf("r%0d_nreads", r), rd_q.size(), m_nreads);
      chk($sformatf("r%0d_rd0", r), (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_DEAD, m_a1);
      if (m_nreads == 2)
        chk($sformatf("r%0d_rd1", r), (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_DEAD, m_a2);
      if (m_kind == 1) begin
        chk($sformatf("r%0d_vaddr", r), vaddr, m_vaddr);
        chk($sformatf("r%0d_paddr", r), paddr, m_paddr);
      end else begin
        chk($sformatf("r%0d_cause", r), 32'(cause), 32'(m_cause));
        chk($sformatf("r%0d_faddr", r), faddr, r_va);
      end
    end

    // Timeout: slave never responds, limit is 4 waiting cycles
    set_ptbr(32'h0010_0000);
    mem.delete();
    hang = 1'b1;
    run_walk(32'h1357_9BDF, 0, 0, 32'h0);
    hang = 1'b0;
    chk("tmo_nflt", n_flt, 1);
    chk("tmo_nupd", n_upd, 0);
    chk("tmo_lat", lat, 6);
    chk("tmo_cause", 32'(cause), 32'd3);
    chk("tmo_faddr", faddr, 32'h1357_9BDF);
    chk("tmo_cyc", cyc_hist & 32'h3F, 32'h1E);
    if (lat > 0 && lat < 30) chk("tmo_busy_after", (busy_hist >> (lat + 1)) & 32'd1, 32'd0);

    // Flush in IDLE has no effect; flush during the L1 wait discards the result
    mem[32'h0010_0004] = 32'h0020_0001;
    mem[32'h0020_0008] = 32'hABCD_E001;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    run_walk(32'h0040_2123, 0, 0, 32'h0);
    chk("idleflush_nupd", n_upd, 1);
    run_walk(32'h0040_2123, 1, 1, 32'h0);
    chk("flush_nupd", n_upd, 0);
    chk("flush_nflt", n_flt, 0);
    chk("flush_nreads", rd_q.size(), 2);
    chk("flush_busy", 32'(busy_o), 32'd0);

    // PTBR write while in L2: current walk keeps old base, next walk uses new
    mem[32'h0030_0004] = 32'h0050_0001;
    mem[32'h0050_0008] = 32'h7777_7001;
    run_walk(32'h0040_2123, 2, 2, 32'h0030_0ABC);
    chk("ptbr_old_nupd", n_upd, 1);
    chk("ptbr_old_paddr", paddr, 32'hABCD_E000);
    chk("ptbr_new_val", ptbr_o, 32'h0030_0000);
    run_walk(32'h0040_2123, 0, 0, 32'h0);
    chk("ptbr_new_rd0", (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_DEAD, 32'h0030_0004);
    chk("ptbr_new_rd1", (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_DEAD, 32'h0050_0008);
    chk("ptbr_new_paddr", paddr, 32'h7777_7000);

    // Back-to-back: miss held high; misses during a walk are ignored
    set_ptbr(32'h0010_0000);
    n_upd = 0; lat = -1; lat2 = -1;
    miss_i = 1'b1;
    miss_addr_i = 32'h0040_2123;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (i == 10) miss_i = 1'b0;
      if (update_o) begin
        n_upd++;
        if (n_upd == 1) lat = i;
        else if (n_upd == 2) lat2 = i;
      end
    end
    chk("b2b_count", n_upd, 2);
    chk("b2b_lat1", lat, 5);
    chk("b2b_lat2", lat2, 10);

    // Reset during the L1 wait
    hang = 1'b1;
    miss_i = 1'b1;
    miss_addr_i = 32'h0040_2123;
    @(negedge clk_i);
    miss_i = 1'b0;
    chk("rst_pre_cyc", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_vals("midrst");
    @(negedge clk_i);
    chk("midrst_cyc_after", 32'(wb_cyc_o), 32'd0);
    hang = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
